// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline fetch stage.
//   word_t         : 32-bit machine word
//   fetch_state_t  : fetch FSM states (RUN, RPEND, HALT)
//   fetch_act_t    : what the fetch stage does with the IF/ID latch on the next edge
//   PC_STEP_DEFAULT, BUBBLE_INSTR : default PC increment and the bubble instruction word
//   word_align()   : clears the byte-offset bits of an address
//   sat_inc()      : saturating increment used by the optional perf counters
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_STEP_DEFAULT = 32'd4;
    localparam word_t BUBBLE_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        RPEND = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,  // PC and IF/ID keep their values
        ACT_REDIR  = 3'd1,  // redirect applied, IF/ID loads a bubble, flush asserted
        ACT_HALT   = 3'd2,  // halt committed, IF/ID loads a bubble
        ACT_BUBBLE = 3'd3,  // no instruction available (miss or halted), bubble
        ACT_FETCH  = 3'd4   // instruction accepted, PC advances
    } fetch_act_t;

    function automatic word_t word_align(input word_t addr);
        return addr & ~32'd3;
    endfunction

    function automatic word_t sat_inc(input word_t value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register, pending-redirect capture and next-PC selection for the fetch stage.
// Ports:
//   CLK, nRST          : clock and asynchronous active-low reset
//   pipe_en, stall     : global advance enable, load-use stall
//   redirect, redirect_pc : taken branch/jump and its target
//   halt_in, ihit      : decode holds halt, instruction memory hit
//   pc_o               : current PC
//   pc_plus_o          : PC + PC_STEP (wraps modulo 2^32)
//   state_o            : current fetch state
//   act_o              : action taken at the coming edge (drives IF/ID, flush, counters)
module fetch_pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = PC_STEP_DEFAULT
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         pipe_en,
    input  logic         stall,
    input  logic         redirect,
    input  word_t        redirect_pc,
    input  logic         halt_in,
    input  logic         ihit,
    output word_t        pc_o,
    output word_t        pc_plus_o,
    output fetch_state_t state_o,
    output fetch_act_t   act_o
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        tgt_q, tgt_d;
    fetch_act_t   act_s;
    word_t        pc_plus_s;

    // Next-state, next-PC and action selection in priority order.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        act_s     = ACT_HOLD;
        pc_plus_s = pc_q + PC_STEP;
        if (!pipe_en) begin
            // Only a running fetch can latch a redirect while the pipe is frozen.
            if (redirect && (state_q == RUN)) begin
                tgt_d   = word_align(redirect_pc);
                state_d = RPEND;
            end else begin
                state_d = state_q;
            end
        end else if (state_q == HALT) begin
            act_s = ACT_BUBBLE;
        end else if (redirect || (state_q == RPEND)) begin
            // A live redirect is newer than any captured target.
            pc_d    = redirect ? word_align(redirect_pc) : tgt_q;
            state_d = RUN;
            act_s   = ACT_REDIR;
        end else if (halt_in) begin
            state_d = HALT;
            act_s   = ACT_HALT;
        end else if (stall) begin
            act_s = ACT_HOLD;
        end else if (!ihit) begin
            act_s = ACT_BUBBLE;
        end else begin
            pc_d  = pc_plus_s;
            act_s = ACT_FETCH;
        end
    end

    // PC, pending target and fetch state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            tgt_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_plus_o = pc_plus_s;
    assign state_o   = state_q;
    assign act_o     = act_s;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: PC (via fetch_pc_reg),
// instruction-memory request, IF/ID latch and optional performance counters.
// Optional feature macro: FETCH_PERF_EN (fetch/bubble counters; tied to 0 when undefined).
// Ports:
//   CLK, nRST                 : clock, asynchronous active-low reset
//   pipe_en, stall            : global advance enable, load-use stall
//   redirect, redirect_pc     : taken branch/jump from a later stage
//   halt_in                   : decode holds a halt instruction
//   ihit, imemload            : instruction memory valid and data
//   imemREN, imemaddr         : instruction memory request
//   IF_Instr_OUT, IF_npc_OUT, IF_valid_OUT : IF/ID latch
//   flush                     : downstream latches load a bubble this edge
//   fetch_count, bubble_count : perf counters
module pipeline_fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = PC_STEP_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pipe_en,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_in,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] IF_Instr_OUT,
    output logic [31:0] IF_npc_OUT,
    output logic        IF_valid_OUT,
    output logic        flush,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    word_t        pc_s;
    word_t        pc_plus_s;
    fetch_state_t state_s;
    fetch_act_t   act_s;
    logic         bubble_s;

    fetch_pc_reg #(
        .PC_INIT (PC_INIT),
        .PC_STEP (PC_STEP)
    ) u_pc (
        .CLK         (CLK),
        .nRST        (nRST),
        .pipe_en     (pipe_en),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .ihit        (ihit),
        .pc_o        (pc_s),
        .pc_plus_o   (pc_plus_s),
        .state_o     (state_s),
        .act_o       (act_s)
    );

    word_t instr_q, instr_d;
    word_t npc_q, npc_d;
    logic  valid_q, valid_d;

    // IF/ID latch next value: bubble, new instruction or hold.
    always_comb begin
        instr_d  = instr_q;
        npc_d    = npc_q;
        valid_d  = valid_q;
        bubble_s = 1'b0;
        case (act_s)
            ACT_REDIR, ACT_HALT, ACT_BUBBLE: begin
                instr_d  = BUBBLE_INSTR;
                npc_d    = 32'h0000_0000;
                valid_d  = 1'b0;
                bubble_s = 1'b1;
            end
            ACT_FETCH: begin
                instr_d = imemload;
                npc_d   = pc_plus_s;
                valid_d = 1'b1;
            end
            default: begin
                bubble_s = 1'b0;
            end
        endcase
    end

    // IF/ID latch registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q <= BUBBLE_INSTR;
            npc_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    // Gating with nRST keeps the request and flush quiet while reset is held.
    assign imemREN      = nRST & (state_s != HALT);
    assign imemaddr     = pc_s;
    assign flush        = nRST & (act_s == ACT_REDIR);
    assign IF_Instr_OUT = instr_q;
    assign IF_npc_OUT   = npc_q;
    assign IF_valid_OUT = valid_q;

`ifdef FETCH_PERF_EN
    word_t fetch_cnt_q, fetch_cnt_d;
    word_t bubble_cnt_q, bubble_cnt_d;

    // Saturating event counters.
    always_comb begin
        fetch_cnt_d  = (act_s == ACT_FETCH) ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
        bubble_cnt_d = bubble_s ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    end

    // Perf counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt_q  <= 32'h0000_0000;
            bubble_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign fetch_count  = 32'h0000_0000;
    assign bubble_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Self-checking bench for pipeline_fetch_stage: a directed vector table, a few
// hand-written multi-cycle sequences and randomized traffic against a reference model.
module tb_pipeline_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_en = 1'b0, stall = 1'b0, redirect = 1'b0, halt_in = 1'b0, ihit = 1'b0;
    logic [31:0] redirect_pc = 32'h0, imemload = 32'h0;
    logic        imemREN, IF_valid_OUT, flush;
    logic [31:0] imemaddr, IF_Instr_OUT, IF_npc_OUT, fetch_count, bubble_count;

    pipeline_fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .pipe_en(pipe_en), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt_in(halt_in), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .IF_Instr_OUT(IF_Instr_OUT),
        .IF_npc_OUT(IF_npc_OUT), .IF_valid_OUT(IF_valid_OUT), .flush(flush),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        pe, st, rd;
        logic [31:0] rpc;
        logic        hl, ih;
        logic [31:0] load;
        logic [31:0] e_addr;
        logic        e_ren, e_flush;
        logic [31:0] e_instr, e_npc;
        logic        e_valid;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_tgt, m_instr, m_npc, m_fc, m_bc;
    bit          m_halted, m_pending, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
        m_fc = 32'h0; m_bc = 32'h0; m_halted = 0; m_pending = 0; m_valid = 0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_npc = 32'h0; m_valid = 0;
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
    endtask

    function automatic bit model_flush(input vec_t v);
        return v.pe && !m_halted && (v.rd || m_pending);
    endfunction

    task automatic model_edge(input vec_t v);
        if (!v.pe) begin
            if (v.rd && !m_halted && !m_pending) begin
                m_pending = 1;
                m_tgt = v.rpc & 32'hFFFF_FFFC;
            end
        end else if (m_halted) begin
            model_bubble();
        end else if (v.rd || m_pending) begin
            m_pc = v.rd ? (v.rpc & 32'hFFFF_FFFC) : m_tgt;
            m_pending = 0;
            model_bubble();
        end else if (v.hl) begin
            m_halted = 1;
            model_bubble();
        end else if (v.st) begin
            // everything holds
        end else if (!v.ih) begin
            model_bubble();
        end else begin
            m_npc = m_pc + 32'd4;
            m_instr = v.load;
            m_valid = 1;
            m_pc = m_npc;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
        end
    endtask

    // One clock: called #1 after a rising edge, returns #1 after the next one.
    task automatic run_cycle(input bit use_tab, input vec_t v);
        logic [31:0] e_addr, e_instr, e_npc;
        logic        e_ren, e_flush, e_valid;
        pipe_en = v.pe; stall = v.st; redirect = v.rd; redirect_pc = v.rpc;
        halt_in = v.hl; ihit = v.ih; imemload = v.load;
        if (use_tab) begin
            e_addr = v.e_addr; e_ren = v.e_ren; e_flush = v.e_flush;
        end else begin
            e_addr = m_pc; e_ren = !m_halted; e_flush = model_flush(v);
        end
        #3;
        chk("imemaddr", imemaddr, e_addr);
        chk("imemREN", {31'd0, imemREN}, {31'd0, e_ren});
        chk("flush", {31'd0, flush}, {31'd0, e_flush});
        @(posedge CLK);
        model_edge(v);
        if (use_tab) begin
            e_instr = v.e_instr; e_npc = v.e_npc; e_valid = v.e_valid;
        end else begin
            e_instr = m_instr; e_npc = m_npc; e_valid = m_valid;
        end
        #1;
        chk("IF_valid", {31'd0, IF_valid_OUT}, {31'd0, e_valid});
        chk("IF_instr", IF_Instr_OUT, e_instr);
        if (e_valid) chk("IF_npc", IF_npc_OUT, e_npc);
`ifdef FETCH_PERF_EN
        chk("fetch_count", fetch_count, m_fc);
        chk("bubble_count", bubble_count, m_bc);
`else
        chk("fetch_count_tied", fetch_count, 32'h0);
        chk("bubble_count_tied", bubble_count, 32'h0);
`endif
    endtask

    // Asserts reset between edges, checks the immediate reset values, then releases.
    task automatic do_reset(input string tag);
        pipe_en = 0; stall = 0; redirect = 0; halt_in = 0; ihit = 0;
        redirect_pc = 32'h0; imemload = 32'h0;
        nRST = 0;
        #1;
        model_reset();
        chk({tag, "_addr"}, imemaddr, 32'h0);
        chk({tag, "_ren"}, {31'd0, imemREN}, 32'h0);
        chk({tag, "_flush"}, {31'd0, flush}, 32'h0);
        chk({tag, "_instr"}, IF_Instr_OUT, 32'h0);
        chk({tag, "_npc"}, IF_npc_OUT, 32'h0);
        chk({tag, "_valid"}, {31'd0, IF_valid_OUT}, 32'h0);
        chk({tag, "_fc"}, fetch_count, 32'h0);
        chk({tag, "_bc"}, bubble_count, 32'h0);
        @(negedge CLK);
        nRST = 1;
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic pe, st, rd, input logic [31:0] rpc,
                                input logic hl, ih, input logic [31:0] load);
        vec_t v;
        v.pe = pe; v.st = st; v.rd = rd; v.rpc = rpc; v.hl = hl; v.ih = ih; v.load = load;
        v.e_addr = 32'h0; v.e_ren = 0; v.e_flush = 0;
        v.e_instr = 32'h0; v.e_npc = 32'h0; v.e_valid = 0;
        return v;
    endfunction

    vec_t tab [16];

    initial begin
        //          pe st rd rpc           hl ih load          addr          ren flush instr         npc           valid
        tab[0]  = '{1, 0, 0, 32'h0,        0, 1, 32'hAAAA_0001, 32'h0,        1, 0, 32'hAAAA_0001, 32'h4,        1};
        tab[1]  = '{1, 0, 0, 32'h0,        0, 1, 32'hBBBB_0002, 32'h4,        1, 0, 32'hBBBB_0002, 32'h8,        1};
        tab[2]  = '{1, 1, 0, 32'h0,        0, 1, 32'hCCCC_0003, 32'h8,        1, 0, 32'hBBBB_0002, 32'h8,        1};
        tab[3]  = '{1, 1, 0, 32'h0,        0, 1, 32'hCCCC_0003, 32'h8,        1, 0, 32'hBBBB_0002, 32'h8,        1};
        tab[4]  = '{1, 0, 0, 32'h0,        0, 1, 32'hCCCC_0003, 32'h8,        1, 0, 32'hCCCC_0003, 32'hC,        1};
        tab[5]  = '{1, 0, 1, 32'h43,       0, 1, 32'hDEAD_0000, 32'hC,        1, 1, 32'h0,         32'h0,        0};
        tab[6]  = '{1, 0, 0, 32'h0,        0, 1, 32'hDDDD_0004, 32'h40,       1, 0, 32'hDDDD_0004, 32'h44,       1};
        tab[7]  = '{0, 0, 1, 32'h80,       0, 1, 32'hEEEE_0005, 32'h44,       1, 0, 32'hDDDD_0004, 32'h44,       1};
        tab[8]  = '{0, 0, 0, 32'h0,        0, 1, 32'hEEEE_0005, 32'h44,       1, 0, 32'hDDDD_0004, 32'h44,       1};
        tab[9]  = '{1, 0, 0, 32'h0,        0, 1, 32'hEEEE_0005, 32'h44,       1, 1, 32'h0,         32'h0,        0};
        tab[10] = '{1, 0, 0, 32'h0,        0, 1, 32'hEEEE_0005, 32'h80,       1, 0, 32'hEEEE_0005, 32'h84,       1};
        tab[11] = '{1, 0, 1, 32'h100,      1, 1, 32'hFFFF_0006, 32'h84,       1, 1, 32'h0,         32'h0,        0};
        tab[12] = '{1, 0, 0, 32'h0,        0, 1, 32'hFFFF_0006, 32'h100,      1, 0, 32'hFFFF_0006, 32'h104,      1};
        tab[13] = '{1, 0, 0, 32'h0,        1, 1, 32'h1234_0007, 32'h104,      1, 0, 32'h0,         32'h0,        0};
        tab[14] = '{1, 0, 1, 32'h200,      0, 1, 32'h1234_0007, 32'h104,      0, 0, 32'h0,         32'h0,        0};
        tab[15] = '{1, 1, 0, 32'h0,        0, 1, 32'h1234_0007, 32'h104,      0, 0, 32'h0,         32'h0,        0};

        do_reset("rst_init");
        for (int i = 0; i < 16; i++) run_cycle(1, tab[i]);

        // Reset while halted.
        do_reset("rst_halt");

        // Three fetches then one miss: counter values from the fetch/bubble rules.
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 1, 32'h1111_1111));
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 1, 32'h2222_2222));
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 1, 32'h3333_3333));
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 0, 32'h4444_4444));
        chk("miss_pc_hold", imemaddr, 32'hC);
`ifdef FETCH_PERF_EN
        chk("perf_fetch3", fetch_count, 32'd3);
        chk("perf_bubble1", bubble_count, 32'd1);
`endif

        // PC wrap at the top of the address space.
        run_cycle(0, mk(1, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'h0));
        chk("wrap_target", imemaddr, 32'hFFFF_FFFC);
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 1, 32'h5555_5555));
        chk("wrap_npc", IF_npc_OUT, 32'h0);
        chk("wrap_pc", imemaddr, 32'h0);

        // Reset while a redirect is pending: the captured target must be dropped.
        run_cycle(0, mk(0, 0, 1, 32'h300, 0, 1, 32'h0));
        do_reset("rst_rpend");
        run_cycle(0, mk(1, 0, 0, 32'h0, 0, 1, 32'h6666_6666));
        chk("rpend_dropped", imemaddr, 32'h4);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            vec_t v;
            v = mk($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 10, $urandom, $urandom_range(0, 99) < 3,
                   $urandom_range(0, 99) < 80, $urandom);
            if ($urandom_range(0, 99) < 2) do_reset("rst_rand");
            run_cycle(0, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
